traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: tracks RED->GREEN->YELLOW->RED, counts cycles,
// and latches the first one-hot, sequence or dwell-timeout fault until cleared.
module traffic_light_monitor #(
  parameter int unsigned MAX_DWELL = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       clear,
  output logic [1:0] phase,
  output logic       fault,
  output logic [1:0] err_code,
  output logic [7:0] cycle_count,
  output logic [7:0] dwell,
  output logic       phase_change
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRK_RED    = 3'd1,
    TRK_GREEN  = 3'd2,
    TRK_YELLOW = 3'd3,
    FAULT      = 3'd4
  } state_e;

  localparam logic [1:0] PH_RED    = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_NONE   = 2'b11;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_SEQ    = 2'b10;
  localparam logic [1:0] ERR_TMO    = 2'b11;

  localparam logic [8:0] MAX_DWELL_C = 9'(MAX_DWELL);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       fault_q, fault_d;
  logic [1:0] err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dwell_q, dwell_d;
  logic       pc_q, pc_d;

  // Lamp mask ordered {red, yellow, green}.
  logic [2:0] lights_s;
  logic       none_s;
  logic       onehot_s;
  logic [2:0] cur_s;
  logic [2:0] succ_s;
  state_e     succ_state_s;
  logic [1:0] succ_phase_s;

  assign lights_s = {red, yellow, green};
  assign none_s   = (lights_s == 3'b000);
  assign onehot_s = (lights_s == 3'b100) || (lights_s == 3'b010) || (lights_s == 3'b001);

  // Expected current lamp and its only legal successor for each tracking state.
  always_comb begin
    cur_s        = 3'b000;
    succ_s       = 3'b000;
    succ_state_s = IDLE;
    succ_phase_s = PH_NONE;
    case (state_q)
      TRK_RED: begin
        cur_s        = 3'b100;
        succ_s       = 3'b001;
        succ_state_s = TRK_GREEN;
        succ_phase_s = PH_GREEN;
      end
      TRK_GREEN: begin
        cur_s        = 3'b001;
        succ_s       = 3'b010;
        succ_state_s = TRK_YELLOW;
        succ_phase_s = PH_YELLOW;
      end
      TRK_YELLOW: begin
        cur_s        = 3'b010;
        succ_s       = 3'b100;
        succ_state_s = TRK_RED;
        succ_phase_s = PH_RED;
      end
      default: begin
        cur_s        = 3'b000;
        succ_s       = 3'b000;
        succ_state_s = IDLE;
        succ_phase_s = PH_NONE;
      end
    endcase
  end

  // Next-state and output computation; clear overrides every detected event.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fault_d = fault_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    pc_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      phase_d = PH_NONE;
      fault_d = 1'b0;
      err_d   = ERR_NONE;
      dwell_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (none_s) begin
            dwell_d = 8'd0;
          end else if (!onehot_s) begin
            state_d = FAULT;
            phase_d = PH_NONE;
            fault_d = 1'b1;
            err_d   = ERR_ONEHOT;
          end else if (red) begin
            state_d = TRK_RED;
            phase_d = PH_RED;
            dwell_d = 8'd1;
          end else begin
            state_d = FAULT;
            phase_d = PH_NONE;
            fault_d = 1'b1;
            err_d   = ERR_SEQ;
          end
        end
        TRK_RED, TRK_GREEN, TRK_YELLOW: begin
          if (!onehot_s) begin
            state_d = FAULT;
            phase_d = PH_NONE;
            fault_d = 1'b1;
            err_d   = ERR_ONEHOT;
          end else if (lights_s == cur_s) begin
            // Dwell freezes at its last legal value when the timeout fires.
            if (({1'b0, dwell_q} + 9'd1) > MAX_DWELL_C) begin
              state_d = FAULT;
              phase_d = PH_NONE;
              fault_d = 1'b1;
              err_d   = ERR_TMO;
            end else begin
              dwell_d = dwell_q + 8'd1;
            end
          end else if (lights_s == succ_s) begin
            state_d = succ_state_s;
            phase_d = succ_phase_s;
            dwell_d = 8'd1;
            pc_d    = 1'b1;
            if ((state_q == TRK_YELLOW) && (cnt_q != 8'hFF)) begin
              cnt_d = cnt_q + 8'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            state_d = FAULT;
            phase_d = PH_NONE;
            fault_d = 1'b1;
            err_d   = ERR_SEQ;
          end
        end
        FAULT: begin
          state_d = FAULT;
          phase_d = PH_NONE;
          fault_d = 1'b1;
        end
        default: begin
          state_d = FAULT;
          phase_d = PH_NONE;
          fault_d = 1'b1;
          err_d   = ERR_SEQ;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_NONE;
      fault_q <= 1'b0;
      err_q   <= ERR_NONE;
      cnt_q   <= 8'd0;
      dwell_q <= 8'd0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fault_q <= fault_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      pc_q    <= pc_d;
    end
  end

  assign phase        = phase_q;
  assign fault        = fault_q;
  assign err_code     = err_q;
  assign cycle_count  = cnt_q;
  assign dwell        = dwell_q;
  assign phase_change = pc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: the driver queues hand-computed
// expectations, a monitor pops one per clock and compares the registered outputs.
module tb_traffic_light_monitor;

  logic       clk;
  logic       rst_n;
  logic       red, yellow, green, clear;
  logic [1:0] phase;
  logic       fault;
  logic [1:0] err_code;
  logic [7:0] cycle_count;
  logic [7:0] dwell;
  logic       phase_change;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] ph;
    logic       f;
    logic [1:0] e;
    logic [7:0] cnt;
    logic [7:0] dw;
    logic       pc;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  traffic_light_monitor #(.MAX_DWELL(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .red(red), .yellow(yellow), .green(green), .clear(clear),
    .phase(phase), .fault(fault), .err_code(err_code),
    .cycle_count(cycle_count), .dwell(dwell), .phase_change(phase_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, %0d expectations still queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check_now(input string nm, input logic [1:0] ph, input logic f,
                           input logic [1:0] e, input logic [7:0] cnt,
                           input logic [7:0] dw, input logic pc);
    vectors++;
    if ({phase, fault, err_code, cycle_count, dwell, phase_change} !== {ph, f, e, cnt, dw, pc}) begin
      miscompares++;
      $display("FAIL %s: got ph=%b f=%b err=%b cnt=%0d dw=%0d pc=%b, want ph=%b f=%b err=%b cnt=%0d dw=%0d pc=%b",
               nm, phase, fault, err_code, cycle_count, dwell, phase_change, ph, f, e, cnt, dw, pc);
    end
  endtask

  // Monitor: one expectation is consumed per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now(e.nm, e.ph, e.f, e.e, e.cnt, e.dw, e.pc);
      end
    end
  end

  task automatic vec(input logic r, input logic y, input logic g, input logic c,
                     input logic [1:0] ph, input logic f, input logic [1:0] e,
                     input logic [7:0] cnt, input logic [7:0] dw, input logic pc,
                     input string nm);
    exp_t x;
    @(negedge clk);
    red = r; yellow = y; green = g; clear = c;
    x.ph = ph; x.f = f; x.e = e; x.cnt = cnt; x.dw = dw; x.pc = pc; x.nm = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    red = 1'b0; yellow = 1'b0; green = 1'b0; clear = 1'b0;
    #12;
    check_now("reset_init", 2'b11, 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle, then two full legal cycles.
    vec(0,0,0,0, 2'b11,0,2'b00, 8'd0,8'd0,0, "idle_none");
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd0,8'd1,0, "seq_r1");
    vec(0,0,1,0, 2'b01,0,2'b00, 8'd0,8'd1,1, "seq_g1");
    vec(0,1,0,0, 2'b10,0,2'b00, 8'd0,8'd1,1, "seq_y1");
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd1,8'd1,1, "seq_r2");
    vec(0,0,1,0, 2'b01,0,2'b00, 8'd1,8'd1,1, "seq_g2");
    vec(0,1,0,0, 2'b10,0,2'b00, 8'd1,8'd1,1, "seq_y2");
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd2,8'd1,1, "seq_r3");

    // Multi-light in green, then fault is sticky against any lights.
    vec(0,0,1,0, 2'b01,0,2'b00, 8'd2,8'd1,1, "mh_green");
    vec(1,0,1,0, 2'b11,1,2'b01, 8'd2,8'd1,0, "mh_fault");
    vec(0,1,0,0, 2'b11,1,2'b01, 8'd2,8'd1,0, "sticky_y");
    vec(1,1,1,0, 2'b11,1,2'b01, 8'd2,8'd1,0, "sticky_multi");
    vec(0,0,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear1");

    // Illegal successor R->Y, then clear.
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd2,8'd1,0, "seqerr_r");
    vec(0,1,0,0, 2'b11,1,2'b10, 8'd2,8'd1,0, "seqerr_y");
    vec(0,0,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear2");

    // Idle boundary cases: green first, multi first, clear beating a light.
    vec(0,0,1,0, 2'b11,1,2'b10, 8'd2,8'd0,0, "idle_green");
    vec(1,0,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear_vs_red");
    vec(1,0,1,0, 2'b11,1,2'b01, 8'd2,8'd0,0, "idle_multi");
    vec(0,0,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear3");
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd2,8'd1,0, "cw_red");
    vec(1,1,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear_wins_multi");

    // Dwell timeout in green: 16 green samples legal, the 17th faults.
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd2,8'd1,0, "tmo_red");
    vec(0,0,1,0, 2'b01,0,2'b00, 8'd2,8'd1,1, "tmo_g1");
    for (int i = 2; i <= 16; i++)
      vec(0,0,1,0, 2'b01,0,2'b00, 8'd2,8'(i),0, "tmo_hold");
    vec(0,0,1,0, 2'b11,1,2'b11, 8'd2,8'd16,0, "tmo_fault");
    vec(0,0,1,0, 2'b11,1,2'b11, 8'd2,8'd16,0, "tmo_frozen");
    vec(0,0,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear4");

    // All lamps off while tracking.
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd2,8'd1,0, "none_red");
    vec(0,0,0,0, 2'b11,1,2'b01, 8'd2,8'd1,0, "none_fault");
    vec(0,0,0,1, 2'b11,0,2'b00, 8'd2,8'd0,0, "clear5");

    // 260 legal cycles: cycle_count saturates at 255.
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd2,8'd1,0, "sat_red0");
    c = 2;
    for (int k = 0; k < 260; k++) begin
      vec(0,0,1,0, 2'b01,0,2'b00, 8'(c),8'd1,1, "sat_g");
      vec(0,1,0,0, 2'b10,0,2'b00, 8'(c),8'd1,1, "sat_y");
      c = (c < 255) ? c + 1 : 255;
      vec(1,0,0,0, 2'b00,0,2'b00, 8'(c),8'd1,1, "sat_r");
    end
    vec(0,0,1,0, 2'b01,0,2'b00, 8'd255,8'd1,1, "sat_hold");

    // Asynchronous reset between edges with a transition pending on the inputs.
    @(posedge clk);
    #3;
    yellow = 1'b1; green = 1'b0; red = 1'b0;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 2'b11, 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check_now("reset_hold", 2'b11, 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    yellow = 1'b0;
    rst_n = 1'b1;
    vec(1,0,0,0, 2'b00,0,2'b00, 8'd0,8'd1,0, "post_reset_red");
    vec(0,0,1,0, 2'b01,0,2'b00, 8'd0,8'd1,1, "post_reset_green");

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d queued expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
